mem_lsu: RTL

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 50 +++++
 rtl/mem_lsu_if.sv | 26 ++
 rtl/mem_load_align.sv | 29 ++
 rtl/mem_lsu.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared CPU defines: access sizes, load/store types, LSU FSM states
// Provides: size encodings, load_type_t, store_type_t, lsu_state_t constants,
// and helpers for misalignment detection and store lane formatting.
package mem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic       read_mem;
        logic       sign;
        logic [1:0] size;
    } load_type_t;

    typedef struct packed {
        logic       dm_wr;
        logic [1:0] size;
    } store_type_t;

    typedef logic [2:0] lsu_state_t;

    localparam lsu_state_t LSU_IDLE  = 3'd0;
    localparam lsu_state_t LSU_REQ   = 3'd1;
    localparam lsu_state_t LSU_WAIT  = 3'd2;
    localparam lsu_state_t LSU_DONE  = 3'd3;
    localparam lsu_state_t LSU_DRAIN = 3'd4;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        return ((size == SZ_HALF) && a[0]) || ((size == SZ_WORD) && (a != 2'b00));
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 4'b0001 << a;
            SZ_HALF: return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store value across all lanes; the strobe picks the live one.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - DCache request/response channel between LSU and data cache
// Request: req_valid/req_ready handshake with req_wr, req_addr, req_wstrb, req_wdata.
// Response: resp_valid/resp_rdata, always accepted by the LSU.
interface mem_lsu_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_wstrb;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wstrb, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wstrb, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - combinational load lane select and sign/zero extension
// Ports: rdata (raw word), addr_lo (byte offset), sign, size -> data (extended result).
module mem_load_align
    import mem_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic        sign,
    input  logic [1:0]  size,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        case (addr_lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: data = {{24{sign & b[7]}}, b};
            SZ_HALF: data = {{16{sign & h[15]}}, h};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit driving a valid/ready DCache port
// Ports: clk, rst (sync active-low); MEM_* pipeline inputs (flush, valid, advance,
// address, store data, load/store type, prior exception); dc (DCache channel,
// master side); MEM_LoadData, MEM_LsuStall, MEM_AdEL, MEM_AdES outputs.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          MEM_Flush,
    input  logic          MEM_Valid,
    input  logic          MEM_Wr,
    input  logic [AW-1:0] MEM_ALUOut,
    input  logic [DW-1:0] MEM_OutB,
    input  load_type_t    MEM_LoadType,
    input  store_type_t   MEM_StoreType,
    input  logic          MEM_ExcValid,
    mem_lsu_if.master     dc,
    output logic [DW-1:0] MEM_LoadData,
    output logic          MEM_LsuStall,
    output logic          MEM_AdEL,
    output logic          MEM_AdES
);
    lsu_state_t  state;
    logic        pending;
    logic        lat_is_load;
    logic        lat_sign;
    logic [1:0]  lat_size;
    logic [1:0]  lat_addr_lo;
    logic [31:0] align_data;

    assign MEM_AdEL = MEM_Valid & MEM_LoadType.read_mem
                      & is_misaligned(MEM_LoadType.size, MEM_ALUOut[1:0]);
    assign MEM_AdES = MEM_Valid & MEM_StoreType.dm_wr
                      & is_misaligned(MEM_StoreType.size, MEM_ALUOut[1:0]);

    assign pending = MEM_Valid & (MEM_LoadType.read_mem | MEM_StoreType.dm_wr)
                     & ~MEM_ExcValid & ~MEM_AdEL & ~MEM_AdES & ~MEM_Flush;

    mem_load_align u_align (
        .rdata   (dc.resp_rdata),
        .addr_lo (lat_addr_lo),
        .sign    (lat_sign),
        .size    (lat_size),
        .data    (align_data)
    );

    // DONE releases the pipeline; DRAIN only stalls for the next instruction.
    always_comb begin
        case (state)
            LSU_IDLE, LSU_DRAIN: MEM_LsuStall = pending;
            LSU_REQ, LSU_WAIT:   MEM_LsuStall = 1'b1;
            default:             MEM_LsuStall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= LSU_IDLE;
            dc.req_valid <= 1'b0;
            dc.req_wr    <= 1'b0;
            dc.req_addr  <= '0;
            dc.req_wstrb <= '0;
            dc.req_wdata <= '0;
            MEM_LoadData <= '0;
            lat_is_load  <= 1'b0;
            lat_sign     <= 1'b0;
            lat_size     <= '0;
            lat_addr_lo  <= '0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (pending) begin
                        state        <= LSU_REQ;
                        dc.req_valid <= 1'b1;
                        dc.req_wr    <= ~MEM_LoadType.read_mem;
                        dc.req_addr  <= {MEM_ALUOut[AW-1:2], 2'b00};
                        dc.req_wstrb <= MEM_LoadType.read_mem ? 4'b0000
                                        : store_strb(MEM_StoreType.size, MEM_ALUOut[1:0]);
                        dc.req_wdata <= MEM_LoadType.read_mem ? '0
                                        : store_data(MEM_StoreType.size, MEM_OutB);
                        lat_is_load  <= MEM_LoadType.read_mem;
                        lat_sign     <= MEM_LoadType.sign;
                        lat_size     <= MEM_LoadType.size;
                        lat_addr_lo  <= MEM_ALUOut[1:0];
                    end
                end
                LSU_REQ: begin
                    if (dc.req_ready) begin
                        dc.req_valid <= 1'b0;
                        // A flushed load already accepted by the cache still owes a response.
                        if (lat_is_load) state <= MEM_Flush ? LSU_DRAIN : LSU_WAIT;
                        else             state <= MEM_Flush ? LSU_IDLE  : LSU_DONE;
                    end else if (MEM_Flush) begin
                        dc.req_valid <= 1'b0;
                        state        <= LSU_IDLE;
                    end
                end
                LSU_WAIT: begin
                    if (dc.resp_valid) begin
                        if (MEM_Flush) begin
                            state <= LSU_IDLE;
                        end else begin
                            MEM_LoadData <= align_data;
                            state        <= LSU_DONE;
                        end
                    end else if (MEM_Flush) begin
                        state <= LSU_DRAIN;
                    end
                end
                LSU_DONE: begin
                    if (MEM_Wr || MEM_Flush) state <= LSU_IDLE;
                end
                LSU_DRAIN: begin
                    if (dc.resp_valid) state <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end
endmodule
